// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core definitions: bus widths, execution-unit source IDs and
// the CDB beat record consumed by the ROB and reservation-station update logic.
package tomasulo_pkg;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TAG_W   = 3;
  localparam int unsigned RSIDX_W = 2;
  localparam int unsigned SRC_W   = 2;

  typedef enum logic [SRC_W-1:0] {
    SRC_RS1_U0 = 2'd0,
    SRC_RS1_U1 = 2'd1,
    SRC_RS2_U0 = 2'd2
  } src_id_t;

  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [DATA_W-1:0]  data;
    src_id_t            src;
    logic [RSIDX_W-1:0] rsidx;
  } cdb_beat_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority picker.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - highest-priority index; search runs ptr, ptr+1, ... with wrap
//   grant - one-hot grant (all zero when req is zero)
//   idx   - encoded index of the granted requester (0 when nothing granted)
module rr_arbiter
  import tomasulo_pkg::*;
#(
  parameter int unsigned N     = NUM_REQ,
  parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] idx
);

  logic             found;
  logic [PTR_W-1:0] pos;
  int unsigned      j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    j     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      // ptr is always < N, so a single subtraction implements the wrap.
      j = 32'(ptr) + k;
      if (j >= N) j = j - N;
      pos = PTR_W'(j);
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one finished execution unit per free slot
// (round-robin from ptr), registers its result and broadcasts it as a single
// beat held until the consumer accepts it.
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   flush                  - squash the pending beat; no grant this cycle
//   req_valid/tag/data/rsidx - per-unit pending result (packed slices)
//   req_ready              - combinational one-hot grant
//   cdb_valid/tag/data/src/rsidx - registered broadcast beat
//   cdb_ready              - consumer accepts the beat this cycle
module cdb_arbiter
  import tomasulo_pkg::*;
#(
  parameter int unsigned NUM_REQ = tomasulo_pkg::NUM_REQ,
  parameter int unsigned DATA_W  = tomasulo_pkg::DATA_W,
  parameter int unsigned TAG_W   = tomasulo_pkg::TAG_W,
  parameter int unsigned RSIDX_W = tomasulo_pkg::RSIDX_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ*RSIDX_W-1:0] req_rsidx,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       cdb_valid,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [DATA_W-1:0]          cdb_data,
  output logic [SRC_W-1:0]           cdb_src,
  output logic [RSIDX_W-1:0]         cdb_rsidx,
  input  logic                       cdb_ready
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   ptr;
  logic [NUM_REQ-1:0] pick;
  logic [PTR_W-1:0]   pick_idx;
  logic               slot_free;
  logic               grant_en;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (pick),
    .idx   (pick_idx)
  );

  assign slot_free = !cdb_valid || cdb_ready;
  // rst_n gates the grant so units never see a handshake while in reset.
  assign grant_en  = slot_free && !flush && rst_n;
  assign req_ready = grant_en ? pick : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
      cdb_rsidx <= '0;
      ptr       <= '0;
    end else if (flush) begin
      cdb_valid <= 1'b0;
    end else if (slot_free) begin
      if (|req_ready) begin
        cdb_valid <= 1'b1;
        cdb_tag   <= req_tag[pick_idx*TAG_W +: TAG_W];
        cdb_data  <= req_data[pick_idx*DATA_W +: DATA_W];
        cdb_rsidx <= req_rsidx[pick_idx*RSIDX_W +: RSIDX_W];
        cdb_src   <= SRC_W'(pick_idx);
        ptr       <= (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

  // Two live requests targeting the same ROB entry is a requester bug.
  logic tag_collision;
  always_comb begin
    tag_collision = 1'b0;
    for (int unsigned a = 0; a < NUM_REQ; a++) begin
      for (int unsigned b = a + 1; b < NUM_REQ; b++) begin
        if (req_valid[a] && req_valid[b] &&
            req_tag[a*TAG_W +: TAG_W] == req_tag[b*TAG_W +: TAG_W])
          tag_collision = 1'b1;
      end
    end
  end

  a_no_tag_collision : assert property (@(posedge clk) disable iff (!rst_n) !tag_collision)
    else $error("cdb_arbiter: two valid requests share one ROB tag");

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Schedules the single common data bus (CDB) among the execution units that finish in the same cycle: RS1 unit 0, RS1 unit 1 and the RS2 unit. Each unit holds its result until it is granted. The granted result is registered and broadcast for one accepted beat to the ROB and to the reservation-station operand-capture logic. Replaces uncoordinated per-unit write-back with one serialized, fair, backpressure-aware broadcast.

Parameters:
NUM_REQ, 3, number of completing execution units (index 0 = RS1 unit 0, 1 = RS1 unit 1, 2 = RS2 unit)
DATA_W, 32, result value width
TAG_W, 3, ROB index width (8-entry ROB)
RSIDX_W, 2, reservation-station entry index width (4 entries per station)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous squash of the CDB output register; no grant this cycle
req_valid  in  NUM_REQ  per unit: result pending
req_tag  in  NUM_REQ*TAG_W  per unit: destination ROB index, slice i = [i*TAG_W +: TAG_W]
req_data  in  NUM_REQ*DATA_W  per unit: result value
req_rsidx  in  NUM_REQ*RSIDX_W  per unit: issuing RS entry, to be freed
req_ready  out  NUM_REQ  one-hot grant; combinational; the unit drops or replaces its request next cycle
cdb_valid  out  1  broadcast beat valid
cdb_tag  out  TAG_W  ROB index being written
cdb_data  out  DATA_W  value being written
cdb_src  out  2  unit index of the beat; the consumer frees RS entry and execution unit
cdb_rsidx  out  RSIDX_W  RS entry to free
cdb_ready  in  1  consumer (ROB/RS update) accepts the beat this cycle

Behaviour:
- Reset (rst_n low, asynchronous): cdb_valid=0; cdb_tag, cdb_data, cdb_src and cdb_rsidx all 0; round-robin pointer ptr=0. req_ready=0 while in reset.
- Slot free: slot_free = !cdb_valid || cdb_ready. Grants occur only when slot_free && !flush && rst_n.
- Arbitration: among the asserted req_valid bits, search from ptr upward with wrap modulo NUM_REQ. The first hit i is granted: req_ready[i]=1, and all other bits are 0.
- Grant effect on the next rising edge: cdb_valid=1 and the output fields load slice i; cdb_src=i; ptr=(i+1) mod NUM_REQ.
- No grant, slot free: cdb_valid=0 next edge; ptr holds.
- Backpressure: cdb_valid && !cdb_ready means no grant, and all outputs hold stable until accepted.
- Latency: request at edge t with slot free gives cdb_valid at edge t+1. Throughput is one beat per cycle while cdb_ready=1.
- Requester rule: while req_valid[i] && !req_ready[i], the tag, data and rsidx slices must stay stable. The arbiter does not latch inputs before grant.
- Fairness: a continuously valid requester is granted within NUM_REQ accepted beats.
- Flush: on the next edge cdb_valid=0 and the beat is discarded even if cdb_ready=1. req_ready is all 0 in the flush cycle. ptr is unchanged.
- Simultaneous flush and rst_n low: reset wins.
- Reset mid-beat: the beat is lost; requesters are cleared by their own reset.
- Tag collision, where two requests carry the same req_tag: illegal. Behaviour is undefined, and a simulation-only assertion flags it.
- Grant on an idle slot is one-hot, never multi-hot. If req_valid==0, then req_ready==0.

Decomposition:
- Shared package tomasulo_pkg:
  - constants DATA_W, TAG_W, RSIDX_W, NUM_REQ
  - source IDs SRC_RS1_U0=0, SRC_RS1_U1=1, SRC_RS2_U0=2
  - packed typedef cdb_beat_t {tag, data, src, rsidx}, which the ROB and RS update logic also use
- One sub-module: rr_arbiter, a combinational rotate-priority picker. Inputs are req and ptr; outputs are a one-hot grant and an encoded index.
- cdb_arbiter owns ptr, the output register and the slot_free, flush and backpressure logic.

Test Plan:
1. Single request, no contention: req_valid=3'b001, tag=5, data=0x0000_00AA, rsidx=2, cdb_ready=1. Expect req_ready=3'b001 that cycle, and next edge cdb_valid=1, tag=5, data=0xAA, src=0, rsidx=2.
2. All three valid every cycle with cdb_ready=1 from reset. Expect grant order 0,1,2,0,1,2; cdb_src follows the same sequence, one beat per cycle.
3. Backpressure: beat src=1, tag=3 pending, cdb_ready=0 for 3 cycles, req_valid=3'b101. Expect req_ready=0 and outputs stable for 3 cycles. On acceptance, the next grant goes to unit 2 (ptr=2), then unit 0.
4. Flush: grant unit 2 (tag=6), then assert flush in the beat cycle with cdb_ready=1. Expect cdb_valid=0 next edge, no req_ready that cycle, and ptr still 0 afterwards.
5. Async reset mid-stream: drop rst_n between clock edges while cdb_valid=1. Expect cdb_valid=0 immediately. After release, the first grant with req_valid=3'b110 goes to unit 1.
6. Starvation bound: unit 0 requests continuously while units 1 and 2 toggle randomly for 1000 cycles, cdb_ready randomized. Check that no requester waits more than 3 accepted beats and that every beat matches the held slice.
